// File: rtl/dma_priority_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dma_priority_arbiter
// Description : DMA channel priority resolution (fixed or rotating) and the
//               HRQ/HLDA hold handshake feeding the timing-control FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module dma_priority_arbiter #(
    parameter int              NCH           = 4,
    parameter logic [2*NCH-1:0] DEFAULT_ORDER = 8'b11_10_01_00
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic [NCH-1:0]     DREQ,
    input  logic               dreqSense,
    input  logic [NCH-1:0]     requestReg,
    input  logic [NCH-1:0]     maskReg,
    input  logic               priorityType,
    input  logic               controllerDisable,
    input  logic               HLDA,
    input  logic               transferDone,
    output logic               HRQ,
    output logic [NCH-1:0]     DACK,
    output logic [1:0]         activeChannel,
    output logic               grantValid,
    output logic [2*NCH-1:0]   priorityOrder
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_GRANT = 2'd2
    } state_t;

    state_t             state_q;
    logic               hrq_q;
    logic [NCH-1:0]     dack_q;
    logic [1:0]         active_q;
    logic               grant_valid_q;
    logic [2*NCH-1:0]   order_q;

    logic [NCH-1:0]     pending_w;
    logic [2*NCH-1:0]   order_eff_w;
    logic [1:0]         winner_w;
    logic [2*NCH-1:0]   order_rot_d;

    // Normalise DREQ polarity, merge software requests, then apply the mask.
    always_comb begin
        pending_w = ((DREQ ^ {NCH{dreqSense}}) | requestReg) & ~maskReg;
    end

    // In IDLE a switch to fixed mode must be honoured at this very decision,
    // even though the register only reloads the default order on this edge.
    always_comb begin
        order_eff_w = order_q;
        if (state_q == S_IDLE && !priorityType) begin
            order_eff_w = DEFAULT_ORDER;
        end
    end

    // Highest-priority pending channel: scan slots from lowest to highest so
    // that slot 0 has the final word.
    always_comb begin
        winner_w = 2'd0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (pending_w[order_eff_w[2*k +: 2]]) begin
                winner_w = order_eff_w[2*k +: 2];
            end
        end
    end

    // Rotated order after serving active_q: the served channel drops to the
    // bottom slot and its successor becomes the highest priority.
    always_comb begin
        order_rot_d = '0;
        for (int k = 0; k < NCH; k++) begin
            order_rot_d[2*k +: 2] = active_q + 2'd1 + 2'(k);
        end
    end

    // Arbitration/handshake FSM with all outputs registered.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q       <= S_IDLE;
            hrq_q         <= 1'b0;
            dack_q        <= '0;
            active_q      <= 2'd0;
            grant_valid_q <= 1'b0;
            order_q       <= DEFAULT_ORDER;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!priorityType) begin
                        order_q <= DEFAULT_ORDER;
                    end
                    if (!controllerDisable && (pending_w != '0)) begin
                        state_q  <= S_REQ;
                        hrq_q    <= 1'b1;
                        active_q <= winner_w;
                    end
                end
                S_REQ: begin
                    if ((pending_w == '0) || controllerDisable) begin
                        state_q  <= S_IDLE;
                        hrq_q    <= 1'b0;
                        active_q <= 2'd0;
                    end else if (HLDA) begin
                        state_q       <= S_GRANT;
                        dack_q        <= NCH'(1) << winner_w;
                        active_q      <= winner_w;
                        grant_valid_q <= 1'b1;
                    end else begin
                        active_q <= winner_w;
                    end
                end
                S_GRANT: begin
                    // Completion wins over a simultaneous HLDA drop.
                    if (transferDone || !HLDA) begin
                        state_q       <= S_IDLE;
                        hrq_q         <= 1'b0;
                        dack_q        <= '0;
                        active_q      <= 2'd0;
                        grant_valid_q <= 1'b0;
                        if (transferDone) begin
                            order_q <= priorityType ? order_rot_d : DEFAULT_ORDER;
                        end
                    end
                end
                default: begin
                    state_q       <= S_IDLE;
                    hrq_q         <= 1'b0;
                    dack_q        <= '0;
                    active_q      <= 2'd0;
                    grant_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign HRQ           = hrq_q;
    assign DACK          = dack_q;
    assign activeChannel = active_q;
    assign grantValid    = grant_valid_q;
    assign priorityOrder = order_q;

endmodule
`default_nettype wire

// File: tb/tb_dma_priority_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dma_priority_arbiter
// Description : Directed, table-driven bench for dma_priority_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dma_priority_arbiter;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic [3:0] DREQ;
    logic       dreqSense;
    logic [3:0] requestReg;
    logic [3:0] maskReg;
    logic       priorityType;
    logic       controllerDisable;
    logic       HLDA;
    logic       transferDone;
    logic       HRQ;
    logic [3:0] DACK;
    logic [1:0] activeChannel;
    logic       grantValid;
    logic [7:0] priorityOrder;

    int checks   = 0;
    int failures = 0;

    dma_priority_arbiter dut (
        .CLK               (CLK),
        .RESET_N           (RESET_N),
        .DREQ              (DREQ),
        .dreqSense         (dreqSense),
        .requestReg        (requestReg),
        .maskReg           (maskReg),
        .priorityType      (priorityType),
        .controllerDisable (controllerDisable),
        .HLDA              (HLDA),
        .transferDone      (transferDone),
        .HRQ               (HRQ),
        .DACK              (DACK),
        .activeChannel     (activeChannel),
        .grantValid        (grantValid),
        .priorityOrder     (priorityOrder)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0] dreq;
        logic       exp_hrq;
        logic [3:0] exp_dack;
    } vec_t;

    vec_t vecs [16];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        RESET_N           = 1'b0;
        DREQ              = 4'b0000;
        dreqSense         = 1'b0;
        requestReg        = 4'b0000;
        maskReg           = 4'b0000;
        priorityType      = 1'b0;
        controllerDisable = 1'b0;
        HLDA              = 1'b0;
        transferDone      = 1'b0;
        tick();
        tick();
        RESET_N = 1'b1;
    endtask

    // Pulse transferDone for one cycle, dropping requests at the same time.
    task automatic finish_service();
        transferDone = 1'b1;
        DREQ         = dreqSense ? 4'b1111 : 4'b0000;
        requestReg   = 4'b0000;
        tick();
        transferDone = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        vecs[0]  = '{4'h0, 1'b0, 4'b0000};
        vecs[1]  = '{4'h1, 1'b1, 4'b0001};
        vecs[2]  = '{4'h2, 1'b1, 4'b0010};
        vecs[3]  = '{4'h3, 1'b1, 4'b0001};
        vecs[4]  = '{4'h4, 1'b1, 4'b0100};
        vecs[5]  = '{4'h5, 1'b1, 4'b0001};
        vecs[6]  = '{4'h6, 1'b1, 4'b0010};
        vecs[7]  = '{4'h7, 1'b1, 4'b0001};
        vecs[8]  = '{4'h8, 1'b1, 4'b1000};
        vecs[9]  = '{4'h9, 1'b1, 4'b0001};
        vecs[10] = '{4'hA, 1'b1, 4'b0010};
        vecs[11] = '{4'hB, 1'b1, 4'b0001};
        vecs[12] = '{4'hC, 1'b1, 4'b0100};
        vecs[13] = '{4'hD, 1'b1, 4'b0001};
        vecs[14] = '{4'hE, 1'b1, 4'b0010};
        vecs[15] = '{4'hF, 1'b1, 4'b0001};

        // Power-on reset state
        do_reset();
        check("rst_hrq",   8'(HRQ),        8'h0);
        check("rst_dack",  8'(DACK),       8'h0);
        check("rst_gv",    8'(grantValid), 8'h0);
        check("rst_act",   8'(activeChannel), 8'h0);
        check("rst_order", priorityOrder,  8'b11_10_01_00);

        // Fixed priority sweep with HLDA tied high
        HLDA = 1'b1;
        for (int i = 0; i < 16; i++) begin
            DREQ = vecs[i].dreq;
            tick();
            check($sformatf("fix_hrq[%0d]", i),  8'(HRQ),  8'(vecs[i].exp_hrq));
            check($sformatf("fix_dack0[%0d]", i), 8'(DACK), 8'h0);
            tick();
            check($sformatf("fix_dack[%0d]", i), 8'(DACK), 8'(vecs[i].exp_dack));
            check($sformatf("fix_gv[%0d]", i),   8'(grantValid), 8'(vecs[i].exp_hrq));
            finish_service();
            check($sformatf("fix_done[%0d]", i), {3'b0, HRQ, DACK}, 8'h0);
            check($sformatf("fix_order[%0d]", i), priorityOrder, 8'b11_10_01_00);
        end

        // Rotating priority, all channels requesting
        do_reset();
        priorityType = 1'b1;
        HLDA         = 1'b1;
        DREQ         = 4'b1111;
        for (int s = 0; s < 4; s++) begin
            logic [3:0] exp_d;
            exp_d = 4'b0001 << s;
            tick();
            check($sformatf("rot_hrq[%0d]", s), 8'(HRQ), 8'h1);
            tick();
            check($sformatf("rot_dack[%0d]", s), 8'(DACK), 8'(exp_d));
            transferDone = 1'b1;
            tick();
            transferDone = 1'b0;
            check($sformatf("rot_end[%0d]", s), {3'b0, HRQ, DACK}, 8'h0);
            if (s == 0) check("rot_order1", priorityOrder, 8'b00_11_10_01);
            if (s == 3) check("rot_order4", priorityOrder, 8'b11_10_01_00);
        end

        // Reset in the middle of a grant, with a rotated order in place
        DREQ = 4'b0001;
        tick(); tick();
        transferDone = 1'b1;
        tick();
        transferDone = 1'b0;
        check("pre_rst_order", priorityOrder, 8'b00_11_10_01);
        tick(); tick();
        check("pre_rst_grant", 8'(DACK), 8'b0001);
        RESET_N = 1'b0;
        tick(); tick();
        check("midrst_hrq",   8'(HRQ),        8'h0);
        check("midrst_dack",  8'(DACK),       8'h0);
        check("midrst_gv",    8'(grantValid), 8'h0);
        check("midrst_order", priorityOrder,  8'b11_10_01_00);
        do_reset();

        // Mask and active-low sense
        dreqSense = 1'b1;
        DREQ      = 4'b1110;
        maskReg   = 4'b0001;
        HLDA      = 1'b1;
        tick();
        check("mask_hrq0", 8'(HRQ), 8'h0);
        tick();
        check("mask_hrq1", 8'(HRQ), 8'h0);
        maskReg = 4'b0000;
        tick();
        check("sense_hrq", 8'(HRQ), 8'h1);
        tick();
        check("sense_dack", 8'(DACK), 8'b0001);
        finish_service();
        requestReg = 4'b0100;
        tick();
        check("sw_hrq", 8'(HRQ), 8'h1);
        tick();
        check("sw_dack", 8'(DACK), 8'b0100);
        finish_service();
        dreqSense = 1'b0;
        DREQ      = 4'b0000;

        // Preempt before HLDA, then withdraw
        do_reset();
        DREQ = 4'b0100;
        tick();
        check("pre_hrq", 8'(HRQ), 8'h1);
        check("pre_act2", 8'(activeChannel), 8'd2);
        DREQ = 4'b0101;
        tick();
        check("pre_act0", 8'(activeChannel), 8'd0);
        check("pre_nodack", 8'(DACK), 8'h0);
        HLDA = 1'b1;
        tick();
        check("pre_dack", 8'(DACK), 8'b0001);
        finish_service();
        HLDA = 1'b0;
        DREQ = 4'b0100;
        tick();
        check("wd_hrq1", 8'(HRQ), 8'h1);
        DREQ = 4'b0000;
        tick();
        check("wd_hrq0", 8'(HRQ), 8'h0);
        HLDA = 1'b1;
        tick();
        check("wd_dack", {3'b0, HRQ, DACK}, 8'h0);

        // Hold revoked in rotating mode
        do_reset();
        priorityType = 1'b1;
        HLDA         = 1'b1;
        DREQ         = 4'b0010;
        tick(); tick();
        check("rev_dack", 8'(DACK), 8'b0010);
        HLDA = 1'b0;
        tick();
        check("rev_clear", {2'b0, grantValid, HRQ, DACK}, 8'h0);
        check("rev_order", priorityOrder, 8'b11_10_01_00);
        tick();
        check("rev_rehrq", 8'(HRQ), 8'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
